// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_if
// Brief    : ROM read bus and instruction hand-off bundle for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_if;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;

    modport master (
        output rom_req_o, rom_addr_o, inst_valid_o, inst_o, instaddr_o,
        input  rom_data_i, id_ready_i
    );

    modport slave (
        input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, instaddr_o,
        output rom_data_i, id_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : PC generator, ROM read issue and prefetch FIFO feeding if_id.
//            Optional misaligned-jump trap enabled by macro IFU_MISALIGN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        jump_en_i,
    input  wire logic [31:0] jump_addr_i,
`ifdef IFU_MISALIGN_EN
    output logic             misalign_o,
`endif
    if_fetch_if.master       bus
);

    localparam int              c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]     c_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_pc;
    logic                 r_inflight;
    logic [31:0]          r_inflight_addr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [31:0]          r_data_mem [FIFO_DEPTH];
    logic [31:0]          r_addr_mem [FIFO_DEPTH];

    logic                 w_jump_bad;
    logic [31:0]          w_jump_tgt;
    logic [c_CNT_W-1:0]   w_occ;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;

`ifdef IFU_MISALIGN_EN
    logic                 r_misalign;
    assign w_jump_bad = jump_en_i && (jump_addr_i[1:0] != 2'b00);
    assign w_jump_tgt = jump_addr_i;
    assign misalign_o = r_misalign;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_misalign <= 1'b0;
        else       r_misalign <= w_jump_bad;
    end
`else
    wire w_unused_jump_lsb = &{1'b0, jump_addr_i[1:0]};
    assign w_jump_bad = 1'b0;
    assign w_jump_tgt = {jump_addr_i[31:2], 2'b00};
`endif

    // Credit counts words already buffered plus the one possibly in flight,
    // so a response always has a free slot even if ID never pops.
    assign w_occ   = r_count + {{(c_CNT_W-1){1'b0}}, r_inflight};
    assign w_valid = (r_count != '0);
    assign w_issue = (r_state == S_RUN) && !jump_en_i && (w_occ < c_DEPTH);
    assign w_push  = r_inflight && !jump_en_i;
    assign w_pop   = w_valid && bus.id_ready_i && !jump_en_i;

    always_comb begin
        w_state_nxt = r_state;
        if (jump_en_i) begin
            w_state_nxt = w_jump_bad ? S_HALT : S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                S_HALT:  w_state_nxt = S_HALT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= RESET_PC;
            r_count         <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
        end else if (jump_en_i) begin
            // Redirect flushes everything; a misaligned target keeps the old pc.
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            if (!w_jump_bad) r_pc <= w_jump_tgt;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_addr <= r_pc;
            if (w_issue) r_pc     <= r_pc + 32'd4;
            if (w_push)  r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= bus.rom_data_i;
            r_addr_mem[r_wr_ptr] <= r_inflight_addr;
        end
    end

    assign bus.rom_req_o    = w_issue;
    assign bus.rom_addr_o   = r_pc;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? r_data_mem[r_rd_ptr] : c_NOP;
    assign bus.instaddr_o   = w_valid ? r_addr_mem[r_rd_ptr] : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Directed self-checking bench for if_fetch (FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_DEPTH    = 4;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jump_en;
    logic [31:0] jump_addr;
`ifdef IFU_MISALIGN_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int base;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
`ifdef IFU_MISALIGN_EN
        .misalign_o  (misalign),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // ROM answers one cycle after a request; garbage otherwise.
    always @(posedge clk)
        bus.rom_data_i <= bus.rom_req_o ? rom_word(bus.rom_addr_o) : 32'hBAD0_BAD0;

    always @(posedge clk)
        if (rstn && bus.inst_valid_o && bus.id_ready_i && !jump_en) begin
            q_addr.push_back(bus.instaddr_o);
            q_data.push_back(bus.inst_o);
        end

    function automatic logic [31:0] q_at(input int i);
        return (i < q_addr.size()) ? q_addr[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn           = 1'b0;
        jump_en        = 1'b0;
        jump_addr      = 32'h0;
        bus.id_ready_i = 1'b1;
        #12;
        check("rst_req",   32'(bus.rom_req_o),    32'h0);
        check("rst_addr",  bus.rom_addr_o,        c_RESET_PC);
        check("rst_valid", 32'(bus.inst_valid_o), 32'h0);
        check("rst_inst",  bus.inst_o,            c_NOP);
        check("rst_iaddr", bus.instaddr_o,        32'h0);
        rstn = 1'b1;

        // Startup stream: IDLE cycle, then requests 0,4,8; first word 2 cycles later.
        tick();
        check("s_req0",   32'(bus.rom_req_o),    32'h1);
        check("s_addr0",  bus.rom_addr_o,        32'h0);
        check("s_val0",   32'(bus.inst_valid_o), 32'h0);
        tick();
        check("s_addr1",  bus.rom_addr_o,        32'h4);
        check("s_val1",   32'(bus.inst_valid_o), 32'h0);
        tick();
        check("s_addr2",  bus.rom_addr_o,        32'h8);
        check("s_val2",   32'(bus.inst_valid_o), 32'h1);
        check("s_iaddr0", bus.instaddr_o,        32'h0);
        check("s_inst0",  bus.inst_o,            rom_word(32'h0));
        tick();
        check("s_iaddr1", bus.instaddr_o,        32'h4);
        tick();
        check("s_iaddr2", bus.instaddr_o,        32'h8);

        // Stall: buffer fills to depth, requests stop, then drain without gaps.
        bus.id_ready_i = 1'b0;
        base = q_addr.size();
        tick(10);
        check("st_req",   32'(bus.rom_req_o),    32'h0);
        check("st_val",   32'(bus.inst_valid_o), 32'h1);
        check("st_head",  bus.instaddr_o,        32'h8);
        check("st_nopop", 32'(q_addr.size() - base), 32'h0);
        bus.id_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("dr_val",   32'(bus.inst_valid_o), 32'h1);
            check("dr_iaddr", bus.instaddr_o,        32'h8 + 32'(4 * i));
            check("dr_inst",  bus.inst_o,            rom_word(32'h8 + 32'(4 * i)));
        end

        // Jump with three words buffered and one request in flight.
        bus.id_ready_i = 1'b0;
        tick();
        jump_en   = 1'b1;
        jump_addr = 32'h100;
        base      = q_addr.size();
        #1;
        check("j_noreq", 32'(bus.rom_req_o), 32'h0);
        tick();
        jump_en        = 1'b0;
        bus.id_ready_i = 1'b1;
        #1;
        check("j_val0", 32'(bus.inst_valid_o), 32'h0);
        check("j_req",  32'(bus.rom_req_o),    32'h1);
        check("j_addr", bus.rom_addr_o,        32'h100);
        tick();
        check("j_val1", 32'(bus.inst_valid_o), 32'h0);
        tick();
        check("j_val2", 32'(bus.inst_valid_o), 32'h1);
        check("j_head", bus.instaddr_o,        32'h100);
        tick(3);
        check("j_q0", q_at(base),     32'h100);
        check("j_q1", q_at(base + 1), 32'h104);
        check("j_d0", (base < q_data.size()) ? q_data[base] : 32'hFFFF_FFFF, rom_word(32'h100));

        // Back-to-back jumps: only the 0x80 stream survives.
        jump_en   = 1'b1;
        jump_addr = 32'h40;
        base      = q_addr.size();
        tick();
        jump_addr = 32'h80;
        #1;
        check("bb_noreq", 32'(bus.rom_req_o), 32'h0);
        tick();
        jump_en = 1'b0;
        #1;
        check("bb_req",  32'(bus.rom_req_o),    32'h1);
        check("bb_addr", bus.rom_addr_o,        32'h80);
        check("bb_val",  32'(bus.inst_valid_o), 32'h0);
        tick(4);
        check("bb_q0", q_at(base),     32'h80);
        check("bb_q1", q_at(base + 1), 32'h84);

        // PC wraps from the top of the address space.
        jump_en   = 1'b1;
        jump_addr = 32'hFFFF_FFF8;
        base      = q_addr.size();
        tick();
        jump_en = 1'b0;
        tick(7);
        check("wr_q0", q_at(base),     32'hFFFF_FFF8);
        check("wr_q1", q_at(base + 1), 32'hFFFF_FFFC);
        check("wr_q2", q_at(base + 2), 32'h0000_0000);
        check("wr_q3", q_at(base + 3), 32'h0000_0004);

`ifndef IFU_MISALIGN_EN
        // Low address bits are dropped on redirect.
        jump_en   = 1'b1;
        jump_addr = 32'h0000_0503;
        tick();
        jump_en = 1'b0;
        #1;
        check("al_addr", bus.rom_addr_o, 32'h0000_0500);
`endif

        // Reset during a stall with two words buffered.
        jump_en        = 1'b1;
        jump_addr      = 32'h300;
        bus.id_ready_i = 1'b0;
        tick();
        jump_en = 1'b0;
        tick(3);
        check("rs_pre_val",  32'(bus.inst_valid_o), 32'h1);
        check("rs_pre_head", bus.instaddr_o,        32'h300);
        rstn = 1'b0;
        #1;
        check("rs_val",   32'(bus.inst_valid_o), 32'h0);
        check("rs_req",   32'(bus.rom_req_o),    32'h0);
        check("rs_addr",  bus.rom_addr_o,        c_RESET_PC);
        check("rs_inst",  bus.inst_o,            c_NOP);
        base           = q_addr.size();
        bus.id_ready_i = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick();
        check("rs_req1",  32'(bus.rom_req_o), 32'h1);
        check("rs_addr1", bus.rom_addr_o,     c_RESET_PC);
        tick(2);
        check("rs_val2",  32'(bus.inst_valid_o), 32'h1);
        check("rs_head",  bus.instaddr_o,        c_RESET_PC);
        tick(2);
        check("rs_q0", q_at(base),     c_RESET_PC);
        check("rs_q1", q_at(base + 1), c_RESET_PC + 32'h4);

`ifdef IFU_MISALIGN_EN
        // Misaligned jump halts fetch until an aligned jump.
        jump_en   = 1'b1;
        jump_addr = 32'h102;
        tick();
        jump_en = 1'b0;
        #1;
        check("ma_pulse", 32'(misalign),         32'h1);
        check("ma_req0",  32'(bus.rom_req_o),    32'h0);
        check("ma_val0",  32'(bus.inst_valid_o), 32'h0);
        tick();
        check("ma_pulse_end", 32'(misalign),      32'h0);
        check("ma_req1",      32'(bus.rom_req_o), 32'h0);
        tick(3);
        check("ma_req2", 32'(bus.rom_req_o),    32'h0);
        check("ma_val2", 32'(bus.inst_valid_o), 32'h0);
        jump_en   = 1'b1;
        jump_addr = 32'h200;
        tick();
        jump_en = 1'b0;
        #1;
        check("ma_res_req",  32'(bus.rom_req_o), 32'h1);
        check("ma_res_addr", bus.rom_addr_o,     32'h200);
        check("ma_res_flag", 32'(misalign),      32'h0);
        tick(2);
        check("ma_res_val",  32'(bus.inst_valid_o), 32'h1);
        check("ma_res_head", bus.instaddr_o,        32'h200);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
